// File: rtl/soc_pkg.sv
// Shared SoC types for the data-side peripheral interconnect: OBI request and
// response structs, address-map rule type, the error-responder read pattern and
// the default six-rule peripheral map with its PMA attributes.
package soc_pkg;

  localparam int unsigned AidWidth = 4;

  localparam logic [31:0] ErrRdata = 32'hBADCAB1E;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;  // inclusive
    logic [31:0] end_addr;    // exclusive
  } addr_map_rule_t;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
  } obi_a_chan_t;

  typedef struct packed {
    logic        req;
    obi_a_chan_t a;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } sbr_obi_rsp_t;

  localparam int unsigned PeriphNumRules = 6;

  // Port 0 is the internal error responder, so rule indices start at 1.
  localparam addr_map_rule_t [PeriphNumRules-1:0] PeriphAddrMap = '{
    0: '{idx: 32'd1, start_addr: 32'h0000_0000, end_addr: 32'h1000_0000},  // flash
    1: '{idx: 32'd2, start_addr: 32'h1000_0000, end_addr: 32'h2000_0000},  // SRAM
    2: '{idx: 32'd3, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000},  // PSRAM
    3: '{idx: 32'd4, start_addr: 32'h3000_0000, end_addr: 32'h3000_1000},  // UART0
    4: '{idx: 32'd5, start_addr: 32'h4000_0000, end_addr: 32'h4000_1000},  // fabric config
    5: '{idx: 32'd6, start_addr: 32'h5000_0000, end_addr: 32'h6000_0000}   // fabric
  };

  typedef struct packed {
    logic cacheable;
    logic executable;
  } pma_t;

  localparam pma_t [PeriphNumRules-1:0] PeriphPma = '{
    0: '{cacheable: 1'b1, executable: 1'b1},
    1: '{cacheable: 1'b1, executable: 1'b1},
    2: '{cacheable: 1'b1, executable: 1'b1},
    3: '{cacheable: 1'b0, executable: 1'b0},
    4: '{cacheable: 1'b0, executable: 1'b0},
    5: '{cacheable: 1'b0, executable: 1'b0}
  };

endpackage

// File: rtl/obi_periph_demux_if.sv
// Manager-side OBI link of the peripheral demux: one request struct from the
// crossbar and one response struct back to it.
interface obi_periph_demux_if
  import soc_pkg::*;
();
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
endinterface

// File: rtl/obi_err_sbr.sv
// OBI error subordinate: always ready, answers every accepted request one cycle
// later with err = 1, rdata = ErrRdata and the request's aid.
// Optional build macro OBI_DEMUX_ERR_CAPTURE_EN adds a sticky first-error
// address capture with a clear input.
module obi_err_sbr
  import soc_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  sbr_obi_req_t req_i,
  output sbr_obi_rsp_t rsp_o
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
  ,
  output logic         err_valid_o,
  output logic [31:0]  err_addr_o,
  input  logic         err_clear_i
`endif
);

  logic                rvalid_r;
  logic [AidWidth-1:0] rid_r;

  // Response register: one response per accepted request, next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      rid_r    <= '0;
    end else begin
      rvalid_r <= req_i.req;
      if (req_i.req) begin
        rid_r <= req_i.a.aid;
      end else begin
        rid_r <= rid_r;
      end
    end
  end

  // Grant is unconditional so the grant path has no dependency on req.
  always_comb begin
    rsp_o         = '0;
    rsp_o.gnt     = 1'b1;
    rsp_o.rvalid  = rvalid_r;
    rsp_o.r.rdata = ErrRdata;
    rsp_o.r.rid   = rid_r;
    rsp_o.r.err   = 1'b1;
  end

`ifdef OBI_DEMUX_ERR_CAPTURE_EN
  logic        err_valid_r;
  logic [31:0] err_addr_r;

  // First-error capture; clear wins over a capture in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_valid_r <= 1'b0;
      err_addr_r  <= 32'h0000_0000;
    end else if (err_clear_i) begin
      err_valid_r <= 1'b0;
    end else if (req_i.req && !err_valid_r) begin
      err_valid_r <= 1'b1;
      err_addr_r  <= req_i.a.addr;
    end else begin
      err_valid_r <= err_valid_r;
    end
  end

  assign err_valid_o = err_valid_r;
  assign err_addr_o  = err_addr_r;

  logic unused_req_s;
  assign unused_req_s = ^{req_i.a.we, req_i.a.be, req_i.a.wdata};
`else
  logic unused_req_s;
  assign unused_req_s = ^{req_i.a.addr, req_i.a.we, req_i.a.be, req_i.a.wdata};
`endif

endmodule

// File: rtl/obi_periph_demux_chk.sv
// Property checker for the outstanding-transaction counter: a response must
// never retire while nothing is outstanding.
module obi_periph_demux_chk (
  input logic clk_i,
  input logic rst_i,
  input logic dec_i,
  input logic cnt_zero_i
);

  // Response retiring with an empty counter would underflow it.
  no_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(dec_i && cnt_zero_i));

endmodule

// File: rtl/obi_periph_demux.sv
// OBI address-decoding demux from the data-side crossbar to the peripheral
// subordinates. Requests and responses are combinational; an outstanding
// counter plus the last granted target keep responses in order by refusing a
// new target until the previous one has drained. Port 0 is never driven: the
// internal obi_err_sbr answers unmapped addresses.
// Optional build macro OBI_DEMUX_ERR_CAPTURE_EN exposes the error capture ports.
module obi_periph_demux
  import soc_pkg::*;
#(
  parameter int unsigned                    NumRules = 6,
  parameter int unsigned                    NumSbr   = 7,
  parameter int unsigned                    MaxTrans = 4,
  parameter addr_map_rule_t [NumRules-1:0]  AddrMap  = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  obi_periph_demux_if.slave          mgr,
  output sbr_obi_req_t [NumSbr-1:0]  sbr_req_o,
  input  sbr_obi_rsp_t [NumSbr-1:0]  sbr_rsp_i,
  output logic                       busy_o
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
  ,
  output logic                       err_valid_o,
  output logic [31:0]                err_addr_o,
  input  logic                       err_clear_i
`endif
);

  localparam int unsigned CntWidth = $clog2(MaxTrans + 1);
  localparam int unsigned SelWidth = (NumSbr > 1) ? $clog2(NumSbr) : 1;

  typedef logic [SelWidth-1:0] sel_t;

  // Lowest-indexed matching rule wins; no match selects the error responder.
  function automatic sel_t decode(input logic [31:0] addr);
    sel_t s;
    logic hit;
    s   = '0;
    hit = 1'b0;
    for (int i = 0; i < NumRules; i++) begin
      if (!hit && (addr >= AddrMap[i].start_addr) && (addr < AddrMap[i].end_addr)) begin
        s   = AddrMap[i].idx[SelWidth-1:0];
        hit = 1'b1;
      end
    end
    return s;
  endfunction

  logic [CntWidth-1:0] cnt_r;
  sel_t                cur_sel_r;
  sel_t                sel_s;
  logic                stall_s;
  logic                sel_gnt_s;
  logic                gnt_s;
  logic                inc_s;
  logic                dec_s;
  sbr_obi_req_t        err_req_s;
  sbr_obi_rsp_t        err_rsp_s;
  sbr_obi_rsp_t        cur_rsp_s;
  sbr_obi_rsp_t        mgr_rsp_s;

  // Decode, stall, request fan-out and response mux.
  always_comb begin
    sel_s     = decode(mgr.req.a.addr);
    cur_rsp_s = err_rsp_s;
    sel_gnt_s = err_rsp_s.gnt;
    for (int k = 1; k < NumSbr; k++) begin
      if (cur_sel_r == sel_t'(k)) begin
        cur_rsp_s = sbr_rsp_i[k];
      end
      if (sel_s == sel_t'(k)) begin
        sel_gnt_s = sbr_rsp_i[k].gnt;
      end
    end
    // A response retiring this cycle frees a slot, so a full counter does not
    // stall then; switching targets still waits for a fully drained counter.
    stall_s = ((cnt_r == CntWidth'(MaxTrans)) && !cur_rsp_s.rvalid) ||
              ((cnt_r != '0) && (sel_s != cur_sel_r));
    gnt_s   = mgr.req.req && sel_gnt_s && !stall_s;
    inc_s   = gnt_s;
    dec_s   = cur_rsp_s.rvalid;

    sbr_req_o = '0;
    for (int k = 1; k < NumSbr; k++) begin
      sbr_req_o[k].a   = mgr.req.a;
      sbr_req_o[k].req = mgr.req.req && !stall_s && (sel_s == sel_t'(k));
    end
    err_req_s     = '0;
    err_req_s.a   = mgr.req.a;
    err_req_s.req = mgr.req.req && !stall_s && (sel_s == '0);

    mgr_rsp_s        = '0;
    mgr_rsp_s.gnt    = gnt_s;
    mgr_rsp_s.rvalid = cur_rsp_s.rvalid;
    mgr_rsp_s.r      = cur_rsp_s.r;
  end

  assign mgr.rsp = mgr_rsp_s;
  assign busy_o  = (cnt_r != '0);

  // Outstanding counter and the target that owns the outstanding responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r     <= '0;
      cur_sel_r <= '0;
    end else begin
      if (inc_s && !dec_s) begin
        cnt_r <= cnt_r + CntWidth'(1);
      end else if (dec_s && !inc_s) begin
        cnt_r <= cnt_r - CntWidth'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (inc_s) begin
        cur_sel_r <= sel_s;
      end else begin
        cur_sel_r <= cur_sel_r;
      end
    end
  end

  obi_err_sbr u_err_sbr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (err_req_s),
    .rsp_o       (err_rsp_s)
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    ,
    .err_valid_o (err_valid_o),
    .err_addr_o  (err_addr_o),
    .err_clear_i (err_clear_i)
`endif
  );

  obi_periph_demux_chk u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .dec_i      (dec_s),
    .cnt_zero_i (cnt_r == '0)
  );

  logic unused_rsp0_s;
  assign unused_rsp0_s = ^sbr_rsp_i[0];

endmodule

// File: tb/tb_obi_periph_demux.sv
// Directed bench for obi_periph_demux: a decode vector table plus hand-written
// sequences for grants, in-order stalls, the outstanding limit, reset and the
// error responder (with capture checks when OBI_DEMUX_ERR_CAPTURE_EN is set).
module tb_obi_periph_demux;
  import soc_pkg::*;

  localparam int unsigned NumSbr = 7;

  // Default map with fabric config widened to overlap the fabric rule.
  localparam addr_map_rule_t [5:0] TbMap = '{
    0: '{idx: 32'd1, start_addr: 32'h0000_0000, end_addr: 32'h1000_0000},
    1: '{idx: 32'd2, start_addr: 32'h1000_0000, end_addr: 32'h2000_0000},
    2: '{idx: 32'd3, start_addr: 32'h2000_0000, end_addr: 32'h3000_0000},
    3: '{idx: 32'd4, start_addr: 32'h3000_0000, end_addr: 32'h3000_1000},
    4: '{idx: 32'd5, start_addr: 32'h4000_0000, end_addr: 32'h5100_0000},
    5: '{idx: 32'd6, start_addr: 32'h5000_0000, end_addr: 32'h6000_0000}
  };

  logic clk = 1'b0;
  logic rst;
  sbr_obi_req_t [NumSbr-1:0] sbr_req;
  sbr_obi_rsp_t [NumSbr-1:0] sbr_rsp;
  logic busy;
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_clear;
`endif

  obi_periph_demux_if mgr_if ();

  always #5 clk = ~clk;

  obi_periph_demux #(
    .NumRules (6),
    .NumSbr   (NumSbr),
    .MaxTrans (4),
    .AddrMap  (TbMap)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mgr         (mgr_if),
    .sbr_req_o   (sbr_req),
    .sbr_rsp_i   (sbr_rsp),
    .busy_o      (busy)
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    ,
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_clear_i (err_clear)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] req_mask();
    logic [6:0] m;
    for (int k = 0; k < NumSbr; k++) m[k] = sbr_req[k].req;
    return m;
  endfunction

  task automatic send(input logic [31:0] addr, input logic we, input logic [3:0] aid);
    mgr_if.req.req     = 1'b1;
    mgr_if.req.a.addr  = addr;
    mgr_if.req.a.we    = we;
    mgr_if.req.a.be    = 4'hF;
    mgr_if.req.a.wdata = 32'hA5A5_0000 | {28'h0, aid};
    mgr_if.req.a.aid   = aid;
  endtask

  task automatic idle();
    mgr_if.req = '0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  mask;
    logic        gnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    mgr_if.req = '0;
    sbr_rsp = '0;
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    err_clear = 1'b0;
`endif
    vecs[0]  = '{32'h0000_0000, 7'b0000010, 1'b0};
    vecs[1]  = '{32'h0FFF_FFFC, 7'b0000010, 1'b0};
    vecs[2]  = '{32'h1000_0000, 7'b0000100, 1'b0};
    vecs[3]  = '{32'h2FFF_FFFF, 7'b0001000, 1'b0};
    vecs[4]  = '{32'h3000_0FFF, 7'b0010000, 1'b0};
    vecs[5]  = '{32'h3000_1000, 7'b0000000, 1'b1};
    vecs[6]  = '{32'h4000_0000, 7'b0100000, 1'b0};
    vecs[7]  = '{32'h5000_0000, 7'b0100000, 1'b0};
    vecs[8]  = '{32'h5100_0000, 7'b1000000, 1'b0};
    vecs[9]  = '{32'h5FFF_FFFF, 7'b1000000, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 7'b0000000, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset gnt", 64'(mgr_if.rsp.gnt), 64'd0);
    check("reset rvalid", 64'(mgr_if.rsp.rvalid), 64'd0);
    check("reset req mask", 64'(req_mask()), 64'd0);
    check("reset cnt", 64'(dut.cnt_r), 64'd0);
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    check("reset err_valid", 64'(err_valid), 64'd0);
`endif

    // Unmapped write answered by the error responder
    @(negedge clk);
    send(32'h6000_0000, 1'b1, 4'h5);
    #1;
    check("err gnt", 64'(mgr_if.rsp.gnt), 64'd1);
    check("err req mask", 64'(req_mask()), 64'd0);
    check("err rvalid early", 64'(mgr_if.rsp.rvalid), 64'd0);
    @(negedge clk);
    idle();
    #1;
    check("err rvalid", 64'(mgr_if.rsp.rvalid), 64'd1);
    check("err flag", 64'(mgr_if.rsp.r.err), 64'd1);
    check("err rdata", 64'(mgr_if.rsp.r.rdata), 64'hBADC_AB1E);
    check("err rid", 64'(mgr_if.rsp.r.rid), 64'h5);
    check("err busy", 64'(busy), 64'd1);
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    check("cap valid", 64'(err_valid), 64'd1);
    check("cap addr", 64'(err_addr), 64'h6000_0000);
`endif
    @(negedge clk);
    #1;
    check("err drained rvalid", 64'(mgr_if.rsp.rvalid), 64'd0);
    check("err drained busy", 64'(busy), 64'd0);

    // SRAM read with a two-cycle response
    @(negedge clk);
    sbr_rsp[2].gnt = 1'b1;
    send(32'h1000_0004, 1'b0, 4'h3);
    #1;
    check("sram mask", 64'(req_mask()), 64'b0000100);
    check("sram gnt", 64'(mgr_if.rsp.gnt), 64'd1);
    @(negedge clk);
    idle();
    sbr_rsp[2].gnt = 1'b0;
    #1;
    check("sram busy", 64'(busy), 64'd1);
    check("sram no rvalid", 64'(mgr_if.rsp.rvalid), 64'd0);
    @(negedge clk);
    sbr_rsp[2].rvalid  = 1'b1;
    sbr_rsp[2].r.rdata = 32'h1234_5678;
    sbr_rsp[2].r.rid   = 4'h3;
    #1;
    check("sram rvalid", 64'(mgr_if.rsp.rvalid), 64'd1);
    check("sram rdata", 64'(mgr_if.rsp.r.rdata), 64'h1234_5678);
    check("sram err", 64'(mgr_if.rsp.r.err), 64'd0);
    check("sram rid", 64'(mgr_if.rsp.r.rid), 64'h3);
    @(negedge clk);
    sbr_rsp = '0;
    #1;
    check("sram done busy", 64'(busy), 64'd0);

    // Decode table, subordinates not granting
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      send(vecs[i].addr, 1'b0, 4'h0);
      #1;
      check($sformatf("decode mask %0h", vecs[i].addr), 64'(req_mask()), 64'(vecs[i].mask));
      check($sformatf("decode gnt %0h", vecs[i].addr), 64'(mgr_if.rsp.gnt), 64'(vecs[i].gnt));
      @(negedge clk);
      idle();
      @(negedge clk);
      #1;
      check("decode idle busy", 64'(busy), 64'd0);
    end

    // Outstanding limit: five flash reads, responses withheld
    @(negedge clk);
    sbr_rsp[1].gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h0000_0100 + 32'(4 * i), 1'b0, 4'(i));
      #1;
      check($sformatf("flash gnt %0d", i), 64'(mgr_if.rsp.gnt), 64'd1);
      @(negedge clk);
    end
    send(32'h0000_0110, 1'b0, 4'h4);
    #1;
    check("full gnt", 64'(mgr_if.rsp.gnt), 64'd0);
    check("full mask", 64'(req_mask()), 64'd0);
    check("full cnt", 64'(dut.cnt_r), 64'd4);
    @(negedge clk);
    #1;
    check("full gnt hold", 64'(mgr_if.rsp.gnt), 64'd0);
    @(negedge clk);
    sbr_rsp[1].rvalid = 1'b1;
    sbr_rsp[1].r.rid  = 4'h0;
    #1;
    check("full gnt on rvalid", 64'(mgr_if.rsp.gnt), 64'd1);
    check("full rvalid", 64'(mgr_if.rsp.rvalid), 64'd1);
    @(negedge clk);
    idle();
    sbr_rsp[1].gnt = 1'b0;
    #1;
    check("full cnt stays", 64'(dut.cnt_r), 64'd4);
    repeat (4) @(negedge clk);
    sbr_rsp = '0;
    #1;
    check("full drained busy", 64'(busy), 64'd0);

    // Flash outstanding, then UART0: UART0 waits for the flash response
    @(negedge clk);
    sbr_rsp[1].gnt = 1'b1;
    sbr_rsp[4].gnt = 1'b1;
    send(32'h0000_0200, 1'b0, 4'h1);
    #1;
    check("order flash gnt", 64'(mgr_if.rsp.gnt), 64'd1);
    @(negedge clk);
    send(32'h3000_0000, 1'b0, 4'h2);
    #1;
    check("order uart stalled gnt", 64'(mgr_if.rsp.gnt), 64'd0);
    check("order uart stalled mask", 64'(req_mask()), 64'd0);
    @(negedge clk);
    #1;
    check("order uart still stalled", 64'(mgr_if.rsp.gnt), 64'd0);
    @(negedge clk);
    sbr_rsp[1].rvalid  = 1'b1;
    sbr_rsp[1].r.rid   = 4'h1;
    sbr_rsp[1].r.rdata = 32'h0000_1111;
    #1;
    check("order flash rvalid", 64'(mgr_if.rsp.rvalid), 64'd1);
    check("order flash rid", 64'(mgr_if.rsp.r.rid), 64'h1);
    check("order uart gnt during rvalid", 64'(mgr_if.rsp.gnt), 64'd0);
    @(negedge clk);
    sbr_rsp[1].rvalid = 1'b0;
    #1;
    check("order uart gnt", 64'(mgr_if.rsp.gnt), 64'd1);
    check("order uart mask", 64'(req_mask()), 64'b0010000);
    @(negedge clk);
    idle();
    sbr_rsp[4].rvalid  = 1'b1;
    sbr_rsp[4].r.rid   = 4'h2;
    sbr_rsp[4].r.rdata = 32'h0000_4444;
    sbr_rsp[1].rvalid  = 1'b1;
    sbr_rsp[1].r.rid   = 4'h7;
    #1;
    check("order uart rvalid", 64'(mgr_if.rsp.rvalid), 64'd1);
    check("order uart rid", 64'(mgr_if.rsp.r.rid), 64'h2);
    check("order uart rdata", 64'(mgr_if.rsp.r.rdata), 64'h4444);
    @(negedge clk);
    sbr_rsp = '0;
    #1;
    check("order done busy", 64'(busy), 64'd0);

    // Reset with two transactions outstanding
    @(negedge clk);
    sbr_rsp[1].gnt = 1'b1;
    send(32'h0000_0300, 1'b0, 4'h0);
    @(negedge clk);
    send(32'h0000_0304, 1'b0, 4'h1);
    @(negedge clk);
    idle();
    sbr_rsp = '0;
    #1;
    check("pre-reset cnt", 64'(dut.cnt_r), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid reset cnt", 64'(dut.cnt_r), 64'd0);
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset rvalid", 64'(mgr_if.rsp.rvalid), 64'd0);

    // Back-to-back unmapped accesses and error capture
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    check("cap cleared", 64'(err_valid), 64'd0);
`endif
    @(negedge clk);
    send(32'h6000_0010, 1'b0, 4'h1);
    #1;
    check("b2b gnt 1", 64'(mgr_if.rsp.gnt), 64'd1);
    @(negedge clk);
    send(32'h7000_0000, 1'b1, 4'h2);
    #1;
    check("b2b gnt 2", 64'(mgr_if.rsp.gnt), 64'd1);
    check("b2b rvalid 1", 64'(mgr_if.rsp.rvalid), 64'd1);
    check("b2b rid 1", 64'(mgr_if.rsp.r.rid), 64'h1);
    @(negedge clk);
    idle();
    #1;
    check("b2b rvalid 2", 64'(mgr_if.rsp.rvalid), 64'd1);
    check("b2b rid 2", 64'(mgr_if.rsp.r.rid), 64'h2);
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    check("cap keeps first addr", 64'(err_addr), 64'h6000_0010);
    check("cap valid b2b", 64'(err_valid), 64'd1);
`endif
    @(negedge clk);
    #1;
    check("b2b done rvalid", 64'(mgr_if.rsp.rvalid), 64'd0);
    check("b2b done busy", 64'(busy), 64'd0);
`ifdef OBI_DEMUX_ERR_CAPTURE_EN
    err_clear = 1'b1;
    #1;
    check("cap valid before clear edge", 64'(err_valid), 64'd1);
    @(negedge clk);
    err_clear = 1'b0;
    #1;
    check("cap valid after clear", 64'(err_valid), 64'd0);
    // Clear and a new error in the same cycle: clear wins
    @(negedge clk);
    err_clear = 1'b1;
    send(32'h6000_0020, 1'b0, 4'h3);
    #1;
    check("cap prio gnt", 64'(mgr_if.rsp.gnt), 64'd1);
    @(negedge clk);
    err_clear = 1'b0;
    idle();
    #1;
    check("cap prio valid", 64'(err_valid), 64'd0);
    @(negedge clk);
    #1;
    check("cap prio valid hold", 64'(err_valid), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
